// File: rtl/csb_axil_bridge.sv
// csb_axil_bridge
// AXI4-Lite slave that forwards each host access to one of NUM_TGT CSB
// (CSR bus) targets. Each access is decoded to a target region, issued as a
// single CSB request, and the target's response is returned on B or R.
// Only one transaction is in flight at a time.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*       AXI4-Lite write channels (AWPROT ignored)
//   s_axi_ar*/r*          AXI4-Lite read channels (ARPROT ignored)
//   csb_req_vld/rdy       one-hot request valid, per-target ready
//   csb_req_pd            {wr, wstrb[3:0], region-local addr, wdata}
//   csb_rsp_vld/pd        per-target response valid, per-target read data
module csb_axil_bridge #(
    parameter int NUM_TGT = 2,
    parameter int REG_AW  = 8,
    parameter int RGN_AW  = 6,
    parameter int TIMEOUT = 1023
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [REG_AW+2-1:0]     s_axi_awaddr,
    input  logic [2:0]              s_axi_awprot,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    input  logic [31:0]             s_axi_wdata,
    input  logic [3:0]              s_axi_wstrb,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    output logic [1:0]              s_axi_bresp,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    input  logic [REG_AW+2-1:0]     s_axi_araddr,
    input  logic [2:0]              s_axi_arprot,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [31:0]             s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic [NUM_TGT-1:0]      csb_req_vld,
    input  logic [NUM_TGT-1:0]      csb_req_rdy,
    output logic [REG_AW+37-1:0]    csb_req_pd,
    input  logic [NUM_TGT-1:0]      csb_rsp_vld,
    input  logic [32*NUM_TGT-1:0]   csb_rsp_pd
);

    localparam int TW = REG_AW - RGN_AW;
    localparam int PW = REG_AW + 37;
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {IDLE, CAPT, REQ, WAIT, ERR, RESP} state_t;

    state_t              state;
    logic                prio_wr;
    logic                is_wr;
    logic [REG_AW-1:0]   waddr;
    logic [CW-1:0]       cnt;

    logic [REG_AW-1:0]   aw_word;
    logic [REG_AW-1:0]   ar_word;
    logic [TW-1:0]       cur_tgt;
    logic                sel_rsp_vld;
    logic [31:0]         sel_rsp_pd;
    logic                unused_ok;

    assign aw_word = s_axi_awaddr[REG_AW+1:2];
    assign ar_word = s_axi_araddr[REG_AW+1:2];
    assign cur_tgt = waddr[REG_AW-1:RGN_AW];

    // Protection bits and byte offsets carry no meaning for word-wide CSRs.
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    function automatic logic tgt_in_range(input logic [REG_AW-1:0] a);
        return int'(a[REG_AW-1:RGN_AW]) < NUM_TGT;
    endfunction

    function automatic logic [NUM_TGT-1:0] tgt_onehot(input logic [REG_AW-1:0] a);
        logic [NUM_TGT-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            if (int'(a[REG_AW-1:RGN_AW]) == i) oh[i] = 1'b1;
        end
        return oh;
    endfunction

    // Request payload carries only the region-local register index.
    function automatic logic [PW-1:0] make_pd(input logic wr, input logic [3:0] strb,
                                              input logic [REG_AW-1:0] a,
                                              input logic [31:0] d);
        return {wr, strb, {TW{1'b0}}, a[RGN_AW-1:0], d};
    endfunction

    // Only the addressed target's response is visible; all others are ignored.
    always_comb begin
        sel_rsp_vld = 1'b0;
        sel_rsp_pd  = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            if (int'(cur_tgt) == i) begin
                sel_rsp_vld = csb_rsp_vld[i];
                sel_rsp_pd  = csb_rsp_pd[32*i +: 32];
            end
        end
    end

    // Transaction FSM. In IDLE the chosen AW/AR ready is raised for one cycle;
    // the following cycle is the address handshake. prio_wr flips to the other
    // direction after each service so simultaneous traffic alternates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            prio_wr       <= 1'b1;
            is_wr         <= 1'b0;
            waddr         <= '0;
            cnt           <= '0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= 2'b00;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= 2'b00;
            csb_req_vld   <= '0;
            csb_req_pd    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_axi_awready) begin
                        s_axi_awready <= 1'b0;
                        if (s_axi_awvalid) begin
                            waddr        <= aw_word;
                            is_wr        <= 1'b1;
                            prio_wr      <= 1'b0;
                            s_axi_wready <= 1'b1;
                            state        <= CAPT;
                        end
                    end else if (s_axi_arready) begin
                        s_axi_arready <= 1'b0;
                        if (s_axi_arvalid) begin
                            waddr      <= ar_word;
                            is_wr      <= 1'b0;
                            prio_wr    <= 1'b1;
                            csb_req_pd <= make_pd(1'b0, 4'h0, ar_word, 32'h0);
                            if (tgt_in_range(ar_word)) begin
                                csb_req_vld <= tgt_onehot(ar_word);
                                state       <= REQ;
                            end else begin
                                state <= ERR;
                            end
                        end
                    end else if (s_axi_awvalid && (prio_wr || !s_axi_arvalid)) begin
                        s_axi_awready <= 1'b1;
                    end else if (s_axi_arvalid) begin
                        s_axi_arready <= 1'b1;
                    end
                end
                CAPT: begin
                    if (s_axi_wvalid) begin
                        s_axi_wready <= 1'b0;
                        csb_req_pd   <= make_pd(1'b1, s_axi_wstrb, waddr, s_axi_wdata);
                        if (tgt_in_range(waddr)) begin
                            csb_req_vld <= tgt_onehot(waddr);
                            state       <= REQ;
                        end else begin
                            state <= ERR;
                        end
                    end
                end
                REQ: begin
                    if (|(csb_req_vld & csb_req_rdy)) begin
                        csb_req_vld <= '0;
                        cnt         <= '0;
                        state       <= WAIT;
                    end
                end
                // The target gets TIMEOUT cycles in WAIT to answer.
                WAIT: begin
                    if (sel_rsp_vld) begin
                        if (is_wr) begin
                            s_axi_bresp  <= RESP_OKAY;
                            s_axi_bvalid <= 1'b1;
                        end else begin
                            s_axi_rresp  <= RESP_OKAY;
                            s_axi_rdata  <= sel_rsp_pd;
                            s_axi_rvalid <= 1'b1;
                        end
                        state <= RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        if (is_wr) begin
                            s_axi_bresp  <= RESP_SLVERR;
                            s_axi_bvalid <= 1'b1;
                        end else begin
                            s_axi_rresp  <= RESP_SLVERR;
                            s_axi_rdata  <= 32'hDEAD_0BAD;
                            s_axi_rvalid <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ERR: begin
                    if (is_wr) begin
                        s_axi_bresp  <= RESP_DECERR;
                        s_axi_bvalid <= 1'b1;
                    end else begin
                        s_axi_rresp  <= RESP_DECERR;
                        s_axi_rdata  <= 32'h0;
                        s_axi_rvalid <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if ((s_axi_bvalid && s_axi_bready) || (s_axi_rvalid && s_axi_rready)) begin
                        s_axi_bvalid <= 1'b0;
                        s_axi_rvalid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
